// File: rtl/bch_wrapper_encoder.sv
// Systematic BCH encoder: shifts a latched message MSB-first through the
// generator-polynomial LFSR and presents {message, parity} with a ready level.
module bch_wrapper_encoder #(
  parameter int unsigned             DATA_BITS = 5,
  parameter int unsigned             ECC_BITS  = 10,
  parameter logic [ECC_BITS:0]       GEN_POLY  = 11'h537,
  parameter int unsigned             BITS      = 1
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_en,
  input  logic                          I_start,
  input  logic [DATA_BITS-1:0]          I_data,
  output logic [DATA_BITS+ECC_BITS-1:0] O_data,
  output logic                          O_ready,
  output logic                          O_busy
);

  localparam int unsigned STEPS = DATA_BITS / BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] msg;
  logic [DATA_BITS-1:0] shreg;
  logic [ECC_BITS-1:0]  lfsr, lfsr_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 fb;

  // BITS message bits folded into the LFSR per enabled cycle, MSB first
  always_comb begin
    fb       = 1'b0;
    lfsr_nxt = lfsr;
    for (int unsigned i = 0; i < BITS; i++) begin
      fb       = shreg[DATA_BITS-1-i] ^ lfsr_nxt[ECC_BITS-1];
      lfsr_nxt = {lfsr_nxt[ECC_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY[ECC_BITS-1:0] : '0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_en && I_start)            state_nxt = SHIFT;
      SHIFT:   if (I_en && (cnt == LAST_STEP)) state_nxt = DONE;
      DONE:    if (I_en)                       state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      msg     <= '0;
      shreg   <= '0;
      lfsr    <= '0;
      cnt     <= '0;
      O_data  <= '0;
      O_ready <= 1'b0;
      O_busy  <= 1'b0;
    end else if (I_en) begin
      case (state)
        IDLE: begin
          if (I_start) begin
            msg     <= I_data;
            shreg   <= I_data;
            lfsr    <= '0;
            cnt     <= '0;
            O_ready <= 1'b0;
            O_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          lfsr  <= lfsr_nxt;
          shreg <= shreg << BITS;
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
          O_data  <= {msg, lfsr};
          O_ready <= 1'b1;
          O_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_wrapper_encoder.sv
// Directed bench for bch_wrapper_encoder: scoreboard of reference codewords
// (long-division model), latency, enable-stall, start-ignore and reset checks.
module tb_bch_wrapper_encoder;

  localparam int unsigned DB = 5;
  localparam int unsigned EB = 10;
  localparam logic [10:0] GP = 11'h537;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          start = 1'b0;
  logic          start5 = 1'b0;
  logic [DB-1:0] data = '0;
  logic [DB-1:0] data5 = '0;
  logic [14:0]   q, q5;
  logic          rdy, bsy, rdy5, bsy5;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  logic [14:0] exp5_q[$];
  logic [14:0] last_cw = '0;
  logic [14:0] got;
  int lat;

  always #5 clk = ~clk;

  bch_wrapper_encoder #(.DATA_BITS(DB), .ECC_BITS(EB), .GEN_POLY(GP), .BITS(1)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_start(start), .I_data(data),
    .O_data(q), .O_ready(rdy), .O_busy(bsy)
  );

  bch_wrapper_encoder #(.DATA_BITS(DB), .ECC_BITS(EB), .GEN_POLY(GP), .BITS(5)) dut5 (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_start(start5), .I_data(data5),
    .O_data(q5), .O_ready(rdy5), .O_busy(bsy5)
  );

  // Reference: polynomial long division of m*x^10 by g(x)
  function automatic logic [14:0] ref_cw(input logic [DB-1:0] m);
    logic [14:0] r;
    r = {m, 10'b0};
    for (int i = 14; i >= 10; i--)
      if (r[i]) r = r ^ (15'(GP) << (i - 10));
    return {m, r[9:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic encode(input logic [DB-1:0] m, input bit toggle);
    @(negedge clk);
    en = 1'b1;
    data = m;
    start = 1'b1;
    exp_q.push_back(ref_cw(m));
    @(posedge clk); #1;
    start = 1'b0;
    data = ~m;
    check("ready_drop", 32'(rdy), 32'd0);
    check("busy_set", 32'(bsy), 32'd1);
    check("data_hold", 32'(q), 32'(last_cw));
    lat = 0;
    while (!rdy && lat < 40) begin
      @(negedge clk);
      if (toggle) begin
        en = ((lat + 1) % 2 == 0);
        start = (lat == 2 || lat == 3);
        data = 5'h1f;
      end
      @(posedge clk); #1;
      lat++;
    end
    en = 1'b1;
    start = 1'b0;
    check(toggle ? "latency_stall" : "latency", 32'(lat), toggle ? 32'd12 : 32'd6);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7fff;
    check("codeword", 32'(q), 32'(got));
    check("busy_clr", 32'(bsy), 32'd0);
    last_cw = got;
  endtask

  initial begin
    #2;
    check("rst_data", 32'(q), 32'd0);
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(rdy), 32'd0);

    encode(5'b00001, 1'b0);
    check("t2_const", 32'(q), 32'(15'b000010100110111));
    encode(5'b00010, 1'b0);
    check("t3_const2", 32'(q), 32'(15'b000101001101110));
    encode(5'b00011, 1'b0);
    check("t3_const3", 32'(q), 32'(15'b000111101011001));
    encode(5'b00000, 1'b0);
    check("t3_zero", 32'(q), 32'd0);

    // Enable stall with ignored start pulses while busy
    encode(5'b00001, 1'b1);
    check("t4_const", 32'(q), 32'(15'b000010100110111));
    repeat (4) @(posedge clk);
    #1;
    check("t4_ready_level", 32'(rdy), 32'd1);
    check("t4_no_requeue", 32'(q), 32'(15'b000010100110111));

    // Enable low freezes everything, even a start request
    @(negedge clk);
    en = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("en_hold_ready", 32'(rdy), 32'd1);
    check("en_hold_busy", 32'(bsy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;

    for (int m = 0; m < 32; m++) encode(DB'(m), 1'b0);

    // Start held high: re-triggers on the edge after DONE
    @(negedge clk);
    data = 5'b10110;
    start = 1'b1;
    exp_q.push_back(ref_cw(5'b10110));
    exp_q.push_back(ref_cw(5'b10110));
    lat = 0;
    @(posedge clk); #1;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency", 32'(lat), 32'd6);
    got = exp_q.pop_front();
    check("b2b_cw1", 32'(q), 32'(got));
    @(posedge clk); #1;
    check("b2b_retrig_ready", 32'(rdy), 32'd0);
    check("b2b_retrig_busy", 32'(bsy), 32'd1);
    start = 1'b0;
    lat = 0;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = exp_q.pop_front();
    check("b2b_cw2", 32'(q), 32'(got));

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    data = 5'b00111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(q), 32'd0);
    check("arst_ready", 32'(rdy), 32'd0);
    check("arst_busy", 32'(bsy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(rdy), 32'd0);
    check("post_rst_busy", 32'(bsy), 32'd0);
    last_cw = '0;
    encode(5'b00011, 1'b0);

    // Five-bits-per-cycle build
    @(negedge clk);
    data5 = 5'b00011;
    start5 = 1'b1;
    exp5_q.push_back(ref_cw(5'b00011));
    @(posedge clk); #1;
    start5 = 1'b0;
    data5 = '0;
    lat = 0;
    while (!rdy5 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bits5_latency", 32'(lat), 32'd2);
    got = exp5_q.pop_front();
    check("bits5_cw", 32'(q5), 32'(got));
    check("bits5_const", 32'(q5), 32'(15'b000111101011001));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
